// File: rtl/image_stream_src.sv
// Synthetic framed pixel-stream source: frame/header/row framing, dimension header, r+c+frame ramp.
// Latency: run seen in IDLE -> FRAME_START one cycle later; all outputs registered. Optional macro: IMAGE_SRC_HBLANK_EN.
module image_stream_src #(
    parameter int DATA_WIDTH  = 16,
    parameter int HEADER_LEN  = 32,
    parameter int VBLANK      = 16,
    parameter int HBLANK      = 4,
    parameter int DTYPE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   run,
    input  logic [DATA_WIDTH-1:0]  num_rows,
    input  logic [DATA_WIDTH-1:0]  num_cols,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]  datao,
    output logic                   busy,
    output logic [DATA_WIDTH-1:0]  frame_cnt
);

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = DTYPE_WIDTH'(1);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = DTYPE_WIDTH'(2);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = DTYPE_WIDTH'(3);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = DTYPE_WIDTH'(4);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END   = DTYPE_WIDTH'(5);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = DTYPE_WIDTH'(6);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = DTYPE_WIDTH'(7);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = DTYPE_WIDTH'(8);

    localparam int HDR_W = 7;
    localparam logic [HDR_W-1:0] IMAGE_NUM_COLS_IDX = HDR_W'(2);
    localparam logic [HDR_W-1:0] IMAGE_NUM_ROWS_IDX = HDR_W'(3);

`ifdef IMAGE_SRC_HBLANK_EN
    localparam bit HBLK_EN = 1'b1;
`else
    localparam bit HBLK_EN = 1'b0;
`endif
    localparam bit HBLK_ON = HBLK_EN && (HBLANK > 0);

    typedef enum logic [3:0] {
        IDLE, FSTART, HSTART, HDR, HEND, RSTART, PIX, REND, HBLK, FEND, VBLK
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   rows_q, rows_d;
    logic [DATA_WIDTH-1:0]   cols_q, cols_d;
    logic [DATA_WIDTH-1:0]   row_q, row_d;
    logic [DATA_WIDTH-1:0]   col_q, col_d;
    logic [HDR_W-1:0]        hdr_q, hdr_d;
    logic [31:0]             blk_q, blk_d;
    logic [DATA_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic                    dvo_q, dvo_d;
    logic [DTYPE_WIDTH-1:0]  dtype_q, dtype_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    adv_row;

    // Each state describes the word registered at the next edge, so outputs lag state by one cycle.
    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        row_d       = row_q;
        col_d       = col_q;
        hdr_d       = hdr_q;
        blk_d       = blk_q;
        frame_cnt_d = frame_cnt_q;
        dvo_d       = 1'b0;
        dtype_d     = '0;
        data_d      = '0;
        busy_d      = (state_q != IDLE);
        adv_row     = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    rows_d  = num_rows;
                    cols_d  = num_cols;
                    state_d = FSTART;
                end
            end
            FSTART: begin
                dvo_d   = 1'b1;
                dtype_d = DTYPE_FRAME_START;
                state_d = HSTART;
            end
            HSTART: begin
                dvo_d   = 1'b1;
                dtype_d = DTYPE_HEADER_START;
                hdr_d   = '0;
                state_d = HDR;
            end
            HDR: begin
                dvo_d   = 1'b1;
                dtype_d = DTYPE_HEADER;
                if (hdr_q == IMAGE_NUM_COLS_IDX) begin
                    data_d = cols_q;
                end else if (hdr_q == IMAGE_NUM_ROWS_IDX) begin
                    data_d = rows_q;
                end
                if (hdr_q == HDR_W'(HEADER_LEN - 1)) begin
                    state_d = HEND;
                end else begin
                    hdr_d = hdr_q + HDR_W'(1);
                end
            end
            HEND: begin
                dvo_d   = 1'b1;
                dtype_d = DTYPE_HEADER_END;
                row_d   = '0;
                state_d = (rows_q == '0) ? FEND : RSTART;
            end
            RSTART: begin
                dvo_d   = 1'b1;
                dtype_d = DTYPE_ROW_START;
                col_d   = '0;
                state_d = (cols_q == '0) ? REND : PIX;
            end
            PIX: begin
                dvo_d   = 1'b1;
                dtype_d = DTYPE_PIXEL;
                data_d  = row_q + col_q + frame_cnt_q;
                if (col_q == cols_q - DATA_WIDTH'(1)) begin
                    state_d = REND;
                end else begin
                    col_d = col_q + DATA_WIDTH'(1);
                end
            end
            REND: begin
                dvo_d   = 1'b1;
                dtype_d = DTYPE_ROW_END;
                if (HBLK_ON) begin
                    blk_d   = '0;
                    state_d = HBLK;
                end else begin
                    adv_row = 1'b1;
                end
            end
            HBLK: begin
                if (blk_q == 32'(HBLANK - 1)) begin
                    adv_row = 1'b1;
                end else begin
                    blk_d = blk_q + 32'd1;
                end
            end
            FEND: begin
                dvo_d       = 1'b1;
                dtype_d     = DTYPE_FRAME_END;
                frame_cnt_d = frame_cnt_q + DATA_WIDTH'(1);
                blk_d       = '0;
                state_d     = (VBLANK == 0) ? IDLE : VBLK;
            end
            VBLK: begin
                if (blk_q == 32'(VBLANK - 1)) begin
                    state_d = IDLE;
                end else begin
                    blk_d = blk_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv_row) begin
            if (row_q == rows_q - DATA_WIDTH'(1)) begin
                state_d = FEND;
            end else begin
                row_d   = row_q + DATA_WIDTH'(1);
                state_d = RSTART;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            hdr_q       <= '0;
            blk_q       <= '0;
            frame_cnt_q <= '0;
            dvo_q       <= 1'b0;
            dtype_q     <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hdr_q       <= hdr_d;
            blk_q       <= blk_d;
            frame_cnt_q <= frame_cnt_d;
            dvo_q       <= dvo_d;
            dtype_q     <= dtype_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
        end
    end

    assign dvo       = dvo_q;
    assign dtypeo    = dtype_q;
    assign datao     = data_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule
